mem_resp_engine: RTL

Downstream stage of the memory command queue. Consumes a request once its latency has matured (the queue's `promote` output). Applies writes to a local word-addressed backing store. Returns read data as a fixed-length burst over a valid/ready response channel. Generates the `promote_ready` input that dequeues the request from the pending queue, and keeps completion counters for the bench and perf monitors.

---
 rtl/mem_resp_engine.sv | 87 ++++++++
 1 files changed

// File: rtl/mem_resp_engine.sv
// mem_resp_engine: consumes matured queue requests, applies writes to a local store,
// and answers reads with a fixed-length burst over a valid/ready response channel.
module mem_resp_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              promote_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic              req_write_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    input  logic [ID_W-1:0]   req_id_in,
    output logic              promote_ready_out,
    output logic              resp_valid_out,
    input  logic              resp_ready_in,
    output logic [DATA_W-1:0] resp_data_out,
    output logic [ID_W-1:0]   resp_id_out,
    output logic              resp_write_out,
    output logic              resp_last_out,
    output logic [15:0]       reads_done_out,
    output logic [15:0]       writes_done_out
);
    typedef enum logic [1:0] {IDLE, READ, WACK} state_t;
    state_t state, state_next;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] rd_addr;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        beat;
    logic              accept, fire, last;
    always_comb begin
        promote_ready_out = state == IDLE;
        accept            = promote_ready_out & promote_in;
        resp_valid_out    = state != IDLE;
        fire              = resp_valid_out & resp_ready_in;
        last              = state == WACK || (state == READ && beat == 4'(BURST_LEN - 1));
        resp_last_out     = last;
        resp_write_out    = state == WACK;
        resp_data_out     = state == READ ? data_q : '0;
        resp_id_out       = resp_valid_out ? id_q : '0;
        state_next        = state;
        if (accept)
            state_next = req_write_in ? WACK : READ;
        else if (fire && last)
            state_next = IDLE;
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end
    // Store has no reset; its contents survive an engine reset.
    always_ff @(posedge clk_in) begin
        if (rst_in && accept && req_write_in)
            mem[req_addr_in] <= req_wdata_in;
    end
    // data_q is prefetched one beat ahead; rd_addr always points at the next beat's word.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            beat            <= '0;
            rd_addr         <= '0;
            id_q            <= '0;
            data_q          <= '0;
            reads_done_out  <= '0;
            writes_done_out <= '0;
        end else begin
            if (accept) begin
                id_q    <= req_id_in;
                beat    <= '0;
                rd_addr <= req_addr_in + ADDR_W'(1);
                data_q  <= mem[req_addr_in];
            end else if (fire && state == READ && !last) begin
                beat    <= beat + 4'd1;
                rd_addr <= rd_addr + ADDR_W'(1);
                data_q  <= mem[rd_addr];
            end
            if (fire && last && state == READ && reads_done_out != 16'hFFFF)
                reads_done_out <= reads_done_out + 16'd1;
            if (fire && state == WACK && writes_done_out != 16'hFFFF)
                writes_done_out <= writes_done_out + 16'd1;
        end
    end
endmodule
